fir_tdm_mac: RTL and testbench



---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_coef_ram.sv | 17 +
 rtl/fir_tdm_mac.sv | 80 ++++++++
 tb/tb_fir_tdm_mac.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and arithmetic helpers for the FIR filter family
package fir_pkg;
  localparam int MAX_W = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, ROUND = 2'd2, HOLD = 2'd3} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // Round half up by 2^shift, then clamp to a signed out_w-bit range
  function automatic logic signed [MAX_W-1:0] sat_round(input logic signed [MAX_W-1:0] acc,
                                                        input int shift, input int out_w);
    logic signed [MAX_W-1:0] half, r, hi;
    half = shift > 0 ? MAX_W'(1) << (shift - 1) : '0;
    r = (acc + half) >>> shift;
    hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    return r > hi ? hi : r < ~hi ? ~hi : r;
  endfunction
endpackage

// File: rtl/fir_coef_ram.sv
// fir_coef_ram: single-port coefficient register file, synchronous write, combinational read
module fir_coef_ram import fir_pkg::*; #(
  parameter int TAPS = 100,
  parameter int COEF_W = 24,
  localparam int AW = clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [COEF_W-1:0] wdata,
  output logic signed [COEF_W-1:0] rdata
);
  logic signed [COEF_W-1:0] mem [TAPS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: time-multiplexed FIR, one shared MAC stepping through one tap per clock
module fir_tdm_mac import fir_pkg::*; #(
  parameter int TAPS = 100,
  parameter int DATA_W = 24,
  parameter int COEF_W = 24,
  parameter int OUT_SHIFT = 23,
  localparam int AW = clog2(TAPS),
  localparam int ACC_W = DATA_W + COEF_W + clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_err,
  output logic                     busy
);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  state_t state;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic [AW-1:0] wptr, k, raddr, ram_addr;
  logic signed [ACC_W-1:0] acc;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic coef_ok;
  assign in_ready = state == IDLE;
  assign busy = state == ACCUM || state == ROUND;
  assign coef_ok = coef_we && state == IDLE && {1'b0, coef_addr} < (AW+1)'(TAPS);
  // The RAM's single port serves software writes in IDLE and tap reads otherwise
  assign ram_addr = state == IDLE ? coef_addr : k;
  assign raddr = wptr >= k ? wptr - k : wptr - k + AW'(TAPS);
  assign prod = dline[raddr] * coef;
  fir_coef_ram #(.TAPS(TAPS), .COEF_W(COEF_W)) u_ram (
    .clk(clk), .we(coef_ok), .addr(ram_addr), .wdata(coef_wdata), .rdata(coef)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      dline <= '{default: '0};
      wptr <= '0;
      k <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      case (state)
        IDLE: if (in_valid) begin
          dline[wptr] <= in_data;
          acc <= '0;
          k <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + ACC_W'(prod);
          k <= k + 1'b1;
          if (k == LAST) begin
            wptr <= wptr == LAST ? '0 : wptr + 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          out_data <= DATA_W'(sat_round(MAX_W'(acc), OUT_SHIFT, DATA_W));
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fir_tdm_mac.sv
// tb_fir_tdm_mac: scoreboard bench, two lockstep DUTs (shift 0 and 1) plus a 5-tap address-range DUT
module tb_fir_tdm_mac;
  localparam int TAPS = 4;
  typedef struct {longint ea; longint eb; int acc_cyc;} exp_t;

  logic clk = 0, reset_n = 0;
  logic in_valid = 0, out_ready = 1, coef_we = 0, coef_we_c = 0;
  logic [15:0] in_data = '0, coef_wdata = '0;
  logic [1:0] coef_addr = '0;
  logic [2:0] coef_addr_c = '0;
  logic in_ready_a, out_valid_a, coef_err_a, busy_a;
  logic in_ready_b, out_valid_b, coef_err_b, busy_b;
  logic in_ready_c, out_valid_c, coef_err_c, busy_c;
  logic signed [15:0] out_data_a, out_data_b, out_data_c;

  int n_chk = 0, n_pass = 0, cyc = 0;
  longint c [TAPS];
  longint hist [TAPS];
  exp_t sb [$];
  logic pv = 0, chk_err = 0, exp_err = 0, rnd_bp = 0;
  int imp_c [TAPS] = '{1, 2, 3, 4};

  fir_tdm_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_a), .busy(busy_a));
  fir_tdm_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_b), .busy(busy_b));
  fir_tdm_mac #(.TAPS(5), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(1'b0), .in_ready(in_ready_c), .in_data(16'h0),
    .out_valid(out_valid_c), .out_ready(1'b1), .out_data(out_data_c), .coef_we(coef_we_c),
    .coef_addr(coef_addr_c), .coef_wdata(16'h0005), .coef_err(coef_err_c), .busy(busy_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd_bp) begin #1 out_ready = $urandom_range(0, 2) != 0; end

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Reference: floor((acc + half) / 2^sh), clamped to 16-bit signed
  function automatic longint model_out(longint acc, int sh);
    real half;
    longint r;
    half = sh > 0 ? 2.0 ** (sh - 1) : 0.0;
    r = longint'($floor((real'(acc) + half) / (2.0 ** sh)));
    return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
  endfunction

  // Observer: mirrors accepted coefficient writes and samples, pushes expectations
  always @(negedge clk) begin
    longint acc;
    if (!reset_n) chk_err = 0;
    else begin
      if (chk_err) begin
        chk("coef_err_a", coef_err_a, exp_err);
        chk("coef_err_b", coef_err_b, exp_err);
      end
      chk_err = coef_we;
      exp_err = coef_we && !in_ready_a;
      if (coef_we && in_ready_a) c[coef_addr] = longint'($signed(coef_wdata));
      if (in_valid && in_ready_a) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'($signed(in_data));
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += c[i] * hist[i];
        sb.push_back('{model_out(acc, 0), model_out(acc, 1), cyc + 1});
      end
    end
  end

  // Monitor: latency on each rising out_valid, data on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) pv = 0;
    else begin
      if (out_valid_a && !pv) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else chk("latency", cyc - sb[0].acc_cyc, TAPS + 1);
      end
      if (out_valid_a && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_a", out_data_a, e.ea);
        chk("out_b", out_data_b, e.eb);
        chk("valid_b", out_valid_b, 1);
      end
      pv = out_valid_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n;
    in_valid = 1;
    in_data = 16'(v);
    n = 0;
    while (!in_ready_a && n < 50) begin step(); n++; end
    if (n == 50) chk("send_timeout", 1, 0);
    step();
    in_valid = 0;
    coef_we = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready_a) && n < 100) begin step(); n++; end
    if (n == 100) chk("drain_timeout", 1, 0);
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we = 1;
    coef_addr = 2'(a);
    coef_wdata = 16'(v);
    step();
    coef_we = 0;
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3);
    wcoef(0, v0); wcoef(1, v1); wcoef(2, v2); wcoef(3, v3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] held;
    int n;
    for (int i = 0; i < TAPS; i++) begin c[i] = 0; hist[i] = 0; end
    repeat (3) step();
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_coef_err", coef_err_a, 0);
    chk("rst_busy", busy_a, 0);
    reset_n = 1;
    step();
    // Impulse response
    load(imp_c[0], imp_c[1], imp_c[2], imp_c[3]);
    send(1);
    repeat (4) send(0);
    drain();
    // Saturation both ways
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    repeat (4) send(16'h7FFF);
    repeat (4) send(16'h8000);
    drain();
    // Rounding on the shift-1 instance
    load(1, 0, 0, 0);
    send(3); send(-3); send(2);
    drain();
    // Backpressure
    out_ready = 0;
    send(7);
    n = 0;
    while (!out_valid_a && n < 20) begin step(); n++; end
    chk("bp_valid_seen", out_valid_a, 1);
    held = out_data_a;
    in_valid = 1;
    in_data = 16'd77;
    repeat (10) begin
      step();
      chk("bp_valid", out_valid_a, 1);
      chk("bp_stable", out_data_a, held);
      chk("bp_in_ready", in_ready_a, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    chk("bp_release_valid", out_valid_a, 0);
    chk("bp_release_ready", in_ready_a, 1);
    drain();
    // Coefficient write while busy is rejected
    load(imp_c[0], imp_c[1], imp_c[2], imp_c[3]);
    send(1);
    step();
    wcoef(0, 100);
    drain();
    // Write in the same cycle as acceptance applies to that sample
    coef_we = 1; coef_addr = 0; coef_wdata = 16'd9;
    send(2);
    drain();
    // Random traffic across many pointer wraps, with random writes and backpressure
    rnd_bp = 1;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        coef_we = 1;
        coef_addr = 2'($urandom_range(0, 3));
        coef_wdata = 16'(int'($urandom_range(0, 15)) - 8);
      end
      send(int'($urandom_range(0, 4095)) - 2048);
    end
    rnd_bp = 0;
    out_ready = 1;
    drain();
    // Reset in the middle of accumulation
    load(imp_c[0], imp_c[1], imp_c[2], imp_c[3]);
    send(5);
    step(); step();
    chk("mid_busy", busy_a, 1);
    reset_n = 0;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    sb.delete();
    #1;
    chk("abort_valid", out_valid_a, 0);
    chk("abort_ready", in_ready_a, 1);
    step();
    reset_n = 1;
    step();
    send(1);
    repeat (3) send(0);
    drain();
    // Out-of-range address on the 5-tap instance
    coef_we_c = 1; coef_addr_c = 3'd5;
    step();
    coef_we_c = 0;
    chk("addr_oob_err", coef_err_c, 1);
    coef_we_c = 1; coef_addr_c = 3'd4;
    step();
    coef_we_c = 0;
    chk("addr_ok_err", coef_err_c, 0);
    step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
